// File: rtl/ysyx_22050550_fetch_ctrl.sv
// Instruction-fetch controller: latches the PC, issues one read, holds the instruction for ID.
// A redirect marks the in-flight fetch killed; its beat is still drained before refetching.
module ysyx_22050550_fetch_ctrl #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              redirect,
   output logic              pc_advance,
   output logic              ar_valid,
   output logic [ADDR_W-1:0] ar_addr,
   input  logic              ar_ready,
   input  logic              r_valid,
   input  logic [DATA_W-1:0] r_data,
   input  logic [1:0]        r_resp,
   output logic              r_ready,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst,
   output logic              if_fault
);

   typedef enum logic [1:0] {LOAD, ADDR, DATA, OUT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              kill_q, kill_d;
   logic              fault_q, fault_d;
   logic              resp_err;

   assign resp_err = (r_resp != 2'b00);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      kill_d  = kill_q;
      fault_d = fault_q;
      case (state_q)
         LOAD: begin
            // pc_in already holds any redirect target here, so no kill is needed
            addr_d  = pc_in;
            kill_d  = 1'b0;
            state_d = ADDR;
         end
         ADDR: begin
            if (redirect) kill_d = 1'b1;
            if (ar_ready) state_d = DATA;
         end
         DATA: begin
            if (r_valid) begin
               if (kill_q || redirect) begin
                  state_d = LOAD;
               end else begin
                  fault_d = resp_err;
                  inst_d  = resp_err ? '0 : (addr_q[2] ? r_data[63:32] : r_data[31:0]);
                  state_d = OUT;
               end
            end else if (redirect) begin
               kill_d = 1'b1;
            end
         end
         OUT: begin
            if (redirect || if_ready) state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= LOAD;
         addr_q  <= '0;
         inst_q  <= '0;
         kill_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         kill_q  <= kill_d;
         fault_q <= fault_d;
      end
   end

   assign ar_valid   = !reset && (state_q == ADDR);
   assign ar_addr    = addr_q;
   assign r_ready    = !reset && (state_q == DATA);
   assign if_valid   = !reset && (state_q == OUT);
   assign if_pc      = addr_q;
   assign if_inst    = inst_q;
   assign if_fault   = !reset && fault_q;
   assign pc_advance = !reset && (state_q == OUT) && if_ready && !redirect;

endmodule

// File: tb/tb_ysyx_22050550_fetch_ctrl.sv
// Directed bench for the fetch controller with a one-beat memory responder and
// scoreboards for issued read addresses and instructions delivered to ID.
module tb_ysyx_22050550_fetch_ctrl;
   localparam int ADDR_W = 64;
   localparam int INST_W = 32;
   localparam int DATA_W = 64;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        fault;
   } dv_t;

   logic              clock = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] pc_in;
   logic              redirect;
   logic              pc_advance;
   logic              ar_valid;
   logic [ADDR_W-1:0] ar_addr;
   logic              ar_ready;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;
   logic              r_ready;
   logic              if_valid;
   logic              if_ready;
   logic [ADDR_W-1:0] if_pc;
   logic [INST_W-1:0] if_inst;
   logic              if_fault;

   int          n_checks = 0;
   int          n_err    = 0;
   int          adv_cnt  = 0;
   int          mem_lat;
   logic [1:0]  mem_resp;
   logic        pend;
   int          cnt;
   logic [63:0] exp_ar[$];
   dv_t         exp_dv[$];

   always #5 clock = ~clock;

   ysyx_22050550_fetch_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset), .pc_in(pc_in), .redirect(redirect),
      .pc_advance(pc_advance), .ar_valid(ar_valid), .ar_addr(ar_addr),
      .ar_ready(ar_ready), .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp),
      .r_ready(r_ready), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
      .if_inst(if_inst), .if_fault(if_fault)
   );

   // Memory: one beat mem_lat cycles after the address handshake
   assign r_data = 64'h0000_0073_0000_0013;
   assign r_resp = mem_resp;
   always @(posedge clock) begin
      if (reset) begin
         r_valid <= 1'b0;
         pend    <= 1'b0;
         cnt     <= 0;
      end else begin
         if (r_valid && r_ready) r_valid <= 1'b0;
         if (ar_valid && ar_ready) begin
            if (mem_lat == 0) r_valid <= 1'b1;
            else begin
               pend <= 1'b1;
               cnt  <= mem_lat - 1;
            end
         end else if (pend) begin
            if (cnt == 0) begin
               r_valid <= 1'b1;
               pend    <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (pc_advance) adv_cnt++;
         if (ar_valid && ar_ready) begin
            chk("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
            if (exp_ar.size() > 0) chk("ar_addr", ar_addr, exp_ar.pop_front());
         end
         if (if_valid && if_ready && !redirect) begin
            chk("dv_expected", 64'(exp_dv.size() > 0), 64'd1);
            if (exp_dv.size() > 0) begin
               dv_t e;
               e = exp_dv.pop_front();
               chk("dv_pc", if_pc, e.pc);
               chk("dv_inst", 64'(if_inst), 64'(e.inst));
               chk("dv_fault", 64'(if_fault), 64'(e.fault));
            end
         end
      end
   end

   task automatic next();
      @(posedge clock);
      #1;
   endtask

   task automatic push_dv(input logic [63:0] pc, input logic [31:0] inst, input logic fault);
      dv_t e;
      e.pc = pc; e.inst = inst; e.fault = fault;
      exp_dv.push_back(e);
   endtask

   task automatic run_until_out(input string tag);
      for (int i = 0; i < 20; i++) begin
         next();
         @(negedge clock);
         if (if_valid) break;
      end
      chk({tag, "_reached_out"}, 64'(if_valid), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; pc_in = 64'h8000_0000; ar_ready = 1'b1; if_ready = 1'b1;
      redirect = 1'b0; mem_lat = 0; mem_resp = 2'b00;
      next(); next();
      @(negedge clock);
      chk("rst_ar_valid", 64'(ar_valid), 64'd0);
      chk("rst_r_ready", 64'(r_ready), 64'd0);
      chk("rst_if_valid", 64'(if_valid), 64'd0);
      chk("rst_pc_advance", 64'(pc_advance), 64'd0);
      chk("rst_if_fault", 64'(if_fault), 64'd0);

      // Straight-line fetch, best-case timing
      exp_ar.push_back(64'h8000_0000);
      push_dv(64'h8000_0000, 32'h0000_0013, 1'b0);
      next(); reset = 1'b0;
      @(negedge clock); chk("t0_ar_valid", 64'(ar_valid), 64'd0);
      next(); @(negedge clock);
      chk("t1_ar_valid", 64'(ar_valid), 64'd1);
      chk("t1_ar_addr", ar_addr, 64'h8000_0000);
      next(); @(negedge clock);
      chk("t2_r_ready", 64'(r_ready), 64'd1);
      next(); @(negedge clock);
      chk("t3_if_valid", 64'(if_valid), 64'd1);
      chk("t3_if_inst", 64'(if_inst), 64'h13);
      chk("t3_if_pc", if_pc, 64'h8000_0000);
      chk("t3_pc_advance", 64'(pc_advance), 64'd1);

      // Upper-word select
      next(); pc_in = 64'h8000_0004;
      exp_ar.push_back(64'h8000_0004);
      push_dv(64'h8000_0004, 32'h0000_0073, 1'b0);
      @(negedge clock);
      chk("t4_pc_advance", 64'(pc_advance), 64'd0);
      chk("t4_if_valid", 64'(if_valid), 64'd0);
      chk("t4_adv_cnt", 64'(adv_cnt), 64'd1);
      run_until_out("upper");
      chk("upper_if_inst", 64'(if_inst), 64'h73);

      // ID backpressure
      next(); pc_in = 64'h8000_0008; if_ready = 1'b0;
      exp_ar.push_back(64'h8000_0008);
      push_dv(64'h8000_0008, 32'h0000_0013, 1'b0);
      run_until_out("bp");
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin next(); @(negedge clock); end
         chk("bp_if_valid", 64'(if_valid), 64'd1);
         chk("bp_if_pc", if_pc, 64'h8000_0008);
         chk("bp_if_inst", 64'(if_inst), 64'h13);
         chk("bp_pc_advance", 64'(pc_advance), 64'd0);
      end
      next(); if_ready = 1'b1;
      @(negedge clock);
      chk("bp_release_adv", 64'(pc_advance), 64'd1);

      // Redirect while waiting for the read beat
      next(); pc_in = 64'h8000_0010; mem_lat = 2;
      exp_ar.push_back(64'h8000_0010);
      @(negedge clock);
      chk("bp_single_pulse", 64'(pc_advance), 64'd0);
      chk("bp_adv_cnt", 64'(adv_cnt), 64'd3);
      for (int i = 0; i < 20; i++) begin
         next(); @(negedge clock);
         if (r_ready) break;
      end
      chk("rd_reached_data", 64'(r_ready), 64'd1);
      next(); redirect = 1'b1; pc_in = 64'h8000_0100;
      exp_ar.push_back(64'h8000_0100);
      push_dv(64'h8000_0100, 32'h0000_0013, 1'b0);
      @(negedge clock);
      chk("rd_wait_r_ready", 64'(r_ready), 64'd1);
      chk("rd_wait_r_valid", 64'(r_valid), 64'd0);
      next(); redirect = 1'b0;
      @(negedge clock);
      chk("rd_beat_valid", 64'(r_valid), 64'd1);
      chk("rd_beat_ready", 64'(r_ready), 64'd1);
      next(); mem_lat = 0;
      @(negedge clock);
      chk("rd_drop_if_valid", 64'(if_valid), 64'd0);
      chk("rd_load_ar_valid", 64'(ar_valid), 64'd0);
      run_until_out("rd");

      // Redirect while the address channel is stalled
      next(); ar_ready = 1'b0; pc_in = 64'h8000_0200;
      exp_ar.push_back(64'h8000_0200);
      for (int i = 0; i < 20; i++) begin
         next(); @(negedge clock);
         if (ar_valid) break;
      end
      chk("ra_a0_addr", ar_addr, 64'h8000_0200);
      next(); redirect = 1'b1; pc_in = 64'h8000_0300;
      @(negedge clock);
      chk("ra_a1_valid", 64'(ar_valid), 64'd1);
      chk("ra_a1_addr", ar_addr, 64'h8000_0200);
      next(); redirect = 1'b0;
      @(negedge clock);
      chk("ra_a2_addr", ar_addr, 64'h8000_0200);
      next(); ar_ready = 1'b1;
      @(negedge clock);
      chk("ra_a3_addr", ar_addr, 64'h8000_0200);
      next();
      exp_ar.push_back(64'h8000_0300);
      push_dv(64'h8000_0300, 32'h0000_0013, 1'b0);
      @(negedge clock);
      chk("ra_beat_consumed", 64'(r_valid && r_ready), 64'd1);
      next(); @(negedge clock);
      chk("ra_drop_if_valid", 64'(if_valid), 64'd0);
      run_until_out("ra");

      // Error response
      next(); pc_in = 64'h8000_0400; mem_resp = 2'd2;
      exp_ar.push_back(64'h8000_0400);
      push_dv(64'h8000_0400, 32'h0, 1'b1);
      run_until_out("fault");
      chk("fault_if_fault", 64'(if_fault), 64'd1);
      chk("fault_if_inst", 64'(if_inst), 64'd0);

      // Redirect together with if_ready in OUT
      next(); mem_resp = 2'd0; pc_in = 64'h8000_0500; if_ready = 1'b0;
      exp_ar.push_back(64'h8000_0500);
      run_until_out("or");
      next(); redirect = 1'b1; if_ready = 1'b1; pc_in = 64'h8000_0600;
      @(negedge clock);
      chk("or_if_valid", 64'(if_valid), 64'd1);
      chk("or_pc_advance", 64'(pc_advance), 64'd0);
      next(); redirect = 1'b0;
      exp_ar.push_back(64'h8000_0600);
      push_dv(64'h8000_0600, 32'h0000_0013, 1'b0);
      @(negedge clock);
      chk("or_load_if_valid", 64'(if_valid), 64'd0);
      chk("or_load_ar_valid", 64'(ar_valid), 64'd0);
      run_until_out("final");

      next(); @(negedge clock);
      chk("total_pc_advance", 64'(adv_cnt), 64'd7);
      chk("ar_queue_drained", 64'(exp_ar.size()), 64'd0);
      chk("dv_queue_drained", 64'(exp_dv.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
